// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared types and default constants for the parametrised serial pattern
// detector (seq_detector_param) and its window sub-module.
//   seq_state_t  : FSM encoding, also exported on state_o for debug/cover
//   DEF_PAT_W    : default pattern length
//   DEF_CNT_W    : default match counter width
//   DEF_RST_PAT  : pattern active after reset (zero-extended to PAT_W)
// -----------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'b00,  // fewer than PAT_W-1 bits collected
        ARMED = 2'b01,  // next accepted bit can complete a match
        MATCH = 2'b10   // previous accepted bit completed a match
    } seq_state_t;

    localparam int          DEF_PAT_W   = 4;
    localparam int          DEF_CNT_W   = 8;
    localparam logic [31:0] DEF_RST_PAT = 32'h0000_000B;

endpackage

// File: rtl/seq_detector_param_if.sv
// -----------------------------------------------------------------------------
// seq_detector_param_if
// Serial-stream bus of the pattern detector.
//   i, in_valid : serial data bit and its qualifier
//   pat_load    : load pat_in as the active pattern (MSB = first bit)
//   cnt_clr     : synchronous clear of match_cnt
//   out         : registered one-cycle match pulse
//   match_cnt   : saturating match count
//   state_o     : current FSM state
// Modports: master drives the stream, slave is the detector.
// -----------------------------------------------------------------------------
interface seq_detector_param_if
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
);

    logic             i;
    logic             in_valid;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             cnt_clr;
    logic             out;
    logic [CNT_W-1:0] match_cnt;
    logic [1:0]       state_o;

    modport master (
        output i, in_valid, pat_load, pat_in, cnt_clr,
        input  out, match_cnt, state_o
    );

    modport slave (
        input  i, in_valid, pat_load, pat_in, cnt_clr,
        output out, match_cnt, state_o
    );

endinterface

// File: rtl/seq_det_window.sv
// -----------------------------------------------------------------------------
// seq_det_window
// History shift register and fill counter of the pattern detector.
//   clk, rst : clock, asynchronous active-high reset
//   shift    : accept bit_in into the history
//   clear    : empty the history (wins over shift)
//   bit_in   : serial data bit
//   window   : candidate window {hist, bit_in}, newest bit at the LSB
//   fill     : number of valid history bits, saturates at PAT_W
// -----------------------------------------------------------------------------
module seq_det_window #(
    parameter int PAT_W  = 4,
    parameter int FILL_W = $clog2(PAT_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift,
    input  logic              clear,
    input  logic              bit_in,
    output logic [PAT_W-1:0]  window,
    output logic [FILL_W-1:0] fill
);

    // Only the newest PAT_W-1 bits can ever be part of a future window, so
    // the oldest bit of the history is shifted out rather than stored.
    logic [PAT_W-2:0] hist;

    assign window = {hist, bit_in};

    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= window[PAT_W-2:0];
            if (fill != FILL_W'(PAT_W))
                fill <= fill + FILL_W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Parametrised serial pattern detector. Pulses out for one cycle whenever the
// last PAT_W accepted bits equal the runtime-programmable pattern, and keeps
// a saturating match counter.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seq_detector_param_if.slave (stream in, pulse/count/state out)
// Parameters: PAT_W (2..32), OVERLAP (1 = overlapping matches), CNT_W,
//             RST_PAT (pattern after reset).
// -----------------------------------------------------------------------------
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT)
) (
    input  logic                clk,
    input  logic                rst,
    seq_detector_param_if.slave bus
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [PAT_W-1:0] pat;
    logic [PAT_W-1:0] window;
    logic [FILL_W-1:0] fill;
    logic             accept;
    logic             armed;
    logic             hit;
    logic             armed_after;
    logic             win_clear;
    logic             out_q;
    logic             out_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // A pattern load discards the bit presented in the same cycle.
    assign accept = bus.in_valid & ~bus.pat_load;
    assign armed  = (state == ARMED) || (state == MATCH);
    assign hit    = accept && armed && (window == pat);

    // Fill after this accepted bit reaches PAT_W-1, so the following bit
    // can complete a match.
    assign armed_after = (int'(fill) + 1) >= (PAT_W - 1);

    seq_det_window #(
        .PAT_W  (PAT_W),
        .FILL_W (FILL_W)
    ) u_window (
        .clk    (clk),
        .rst    (rst),
        .shift  (accept),
        .clear  (win_clear),
        .bit_in (bus.i),
        .window (window),
        .fill   (fill)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FILL;
        else
            state <= state_nxt;
    end

    // Next-state logic; also decides when the history is emptied.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        win_clear = 1'b0;
        if (bus.pat_load) begin
            state_nxt = FILL;
            win_clear = 1'b1;
        end else begin
            case (state)
                FILL, ARMED, MATCH: begin
                    if (hit) begin
                        if (OVERLAP) begin
                            state_nxt = MATCH;
                        end else begin
                            state_nxt = FILL;
                            win_clear = 1'b1;
                        end
                    end else if (accept) begin
                        state_nxt = armed_after ? ARMED : FILL;
                    end else if (state == MATCH) begin
                        state_nxt = OVERLAP ? ARMED : FILL;
                    end
                end
                default: begin
                    // Unused encoding: restart collection from scratch.
                    state_nxt = FILL;
                    win_clear = 1'b1;
                end
            endcase
        end
    end

    // Output logic: match pulse and saturating counter, clear wins.
    always_comb begin
        out_nxt = hit;
        cnt_nxt = cnt;
        if (bus.cnt_clr)
            cnt_nxt = '0;
        else if (hit && (cnt != '1))
            cnt_nxt = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat   <= RST_PAT;
            out_q <= 1'b0;
            cnt   <= '0;
        end else begin
            if (bus.pat_load)
                pat <= bus.pat_in;
            out_q <= out_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign bus.out       = out_q;
    assign bus.match_cnt = cnt;
    assign bus.state_o   = state;

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
// Directed bench for seq_detector_param. Four instances share one stimulus:
//   dut_a : PAT_W=4, OVERLAP=1, CNT_W=8
//   dut_b : PAT_W=4, OVERLAP=0, CNT_W=8
//   dut_c : PAT_W=4, OVERLAP=1, CNT_W=2
//   dut_d : PAT_W=8, OVERLAP=1, CNT_W=8
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       i;
    logic       in_valid;
    logic       pat_load;
    logic       cnt_clr;
    logic [7:0] pat_in8;

    int vectors     = 0;
    int miscompares = 0;

    // Directed stream and hand-computed pulses for pattern 1011.
    logic s1    [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic e1a   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic e1b   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    // Eight 1s after loading 1111 on top of counts of 2.
    logic e2a   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int   e2cnt [8] = '{2, 2, 2, 3, 4, 5, 6, 7};
    int   e2c   [8] = '{2, 2, 2, 3, 3, 3, 3, 3};

    logic [7:0] pv;

    seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) if_a ();
    seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) if_b ();
    seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) if_c ();
    seq_detector_param_if #(.PAT_W(8), .CNT_W(8)) if_d ();

    assign if_a.i = i;  assign if_a.in_valid = in_valid;  assign if_a.pat_load = pat_load;
    assign if_a.cnt_clr = cnt_clr;  assign if_a.pat_in = pat_in8[3:0];
    assign if_b.i = i;  assign if_b.in_valid = in_valid;  assign if_b.pat_load = pat_load;
    assign if_b.cnt_clr = cnt_clr;  assign if_b.pat_in = pat_in8[3:0];
    assign if_c.i = i;  assign if_c.in_valid = in_valid;  assign if_c.pat_load = pat_load;
    assign if_c.cnt_clr = cnt_clr;  assign if_c.pat_in = pat_in8[3:0];
    assign if_d.i = i;  assign if_d.in_valid = in_valid;  assign if_d.pat_load = pat_load;
    assign if_d.cnt_clr = cnt_clr;  assign if_d.pat_in = pat_in8;

    seq_detector_param #(.PAT_W(4), .OVERLAP(1'b1), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    seq_detector_param #(.PAT_W(4), .OVERLAP(1'b0), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    seq_detector_param #(.PAT_W(4), .OVERLAP(1'b1), .CNT_W(2)) dut_c (.clk(clk), .rst(rst), .bus(if_c));
    seq_detector_param #(.PAT_W(8), .OVERLAP(1'b1), .CNT_W(8)) dut_d (.clk(clk), .rst(rst), .bus(if_d));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        i        = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Load with a valid 1 on the line, which must be discarded.
    task automatic load(input logic [7:0] p);
        pat_in8  = p;
        pat_load = 1'b1;
        in_valid = 1'b1;
        i        = 1'b1;
        tick();
        pat_load = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        i        = 1'b0;
        in_valid = 1'b0;
        pat_load = 1'b0;
        cnt_clr  = 1'b0;
        pat_in8  = 8'h00;
        tick();
        tick();

        // Reset state.
        check("rst_a_out",   32'(if_a.out),       0);
        check("rst_a_cnt",   32'(if_a.match_cnt), 0);
        check("rst_a_state", 32'(if_a.state_o),   0);
        check("rst_d_cnt",   32'(if_d.match_cnt), 0);
        rst = 1'b0;

        // Default pattern 1011, overlapping vs non-overlapping.
        for (int k = 0; k < 7; k++) begin
            send(s1[k]);
            check($sformatf("p1_a_out_b%0d", k + 1), 32'(if_a.out), 32'(e1a[k]));
            check($sformatf("p1_b_out_b%0d", k + 1), 32'(if_b.out), 32'(e1b[k]));
            if (k == 3) begin
                check("p1_a_state_match", 32'(if_a.state_o), 2);
                check("p1_b_state_fill",  32'(if_b.state_o), 0);
            end
        end
        check("p1_a_cnt", 32'(if_a.match_cnt), 2);
        check("p1_b_cnt", 32'(if_b.match_cnt), 1);
        check("p1_c_cnt", 32'(if_c.match_cnt), 2);

        // Load 1111: the bit on the line is dropped, count untouched.
        load(8'h0F);
        check("p2_a_out_load",   32'(if_a.out),       0);
        check("p2_a_state_load", 32'(if_a.state_o),   0);
        check("p2_a_cnt_load",   32'(if_a.match_cnt), 2);
        for (int k = 0; k < 8; k++) begin
            send(1'b1);
            check($sformatf("p2_a_out_b%0d", k + 1), 32'(if_a.out),       32'(e2a[k]));
            check($sformatf("p2_a_cnt_b%0d", k + 1), 32'(if_a.match_cnt), 32'(e2cnt[k]));
            check($sformatf("p2_c_cnt_b%0d", k + 1), 32'(if_c.match_cnt), 32'(e2c[k]));
        end

        // Clear coincident with a match: clear wins, pulse still fires.
        cnt_clr = 1'b1;
        send(1'b1);
        cnt_clr = 1'b0;
        check("p3_a_out_clr", 32'(if_a.out),       1);
        check("p3_a_cnt_clr", 32'(if_a.match_cnt), 0);
        check("p3_c_out_clr", 32'(if_c.out),       1);
        check("p3_c_cnt_clr", 32'(if_c.match_cnt), 0);
        send(1'b1);
        check("p3_c_cnt_after", 32'(if_c.match_cnt), 1);

        // Idle gaps do not break the sequence.
        do_reset();
        send(1'b1);
        send(1'b0);
        check("p4_out_b2", 32'(if_a.out), 0);
        for (int k = 0; k < 3; k++) begin
            idle();
            check($sformatf("p4_out_idle%0d", k), 32'(if_a.out),     0);
            check($sformatf("p4_st_idle%0d", k),  32'(if_a.state_o), 0);
        end
        send(1'b1);
        check("p4_state_armed", 32'(if_a.state_o), 1);
        check("p4_out_b3",      32'(if_a.out),     0);
        send(1'b1);
        check("p4_out_gap_match", 32'(if_a.out),       1);
        check("p4_cnt_gap_match", 32'(if_a.match_cnt), 1);

        // Asynchronous reset mid-sequence, with a completing bit on the line.
        send(1'b1);
        send(1'b0);
        send(1'b1);
        check("p4_out_101", 32'(if_a.out), 0);
        i        = 1'b1;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("p4_rst_out",   32'(if_a.out),            0);
        check("p4_rst_cnt",   32'(if_a.match_cnt),      0);
        check("p4_rst_fill",  32'(dut_a.u_window.fill), 0);
        check("p4_rst_state", 32'(if_a.state_o),        0);
        tick();
        check("p4_rst_lost", 32'(if_a.out), 0);
        in_valid = 1'b0;
        rst      = 1'b0;
        idle();
        check("p4_deassert_out", 32'(if_a.out), 0);
        send(1'b1);
        check("p4_lone_one", 32'(if_a.out), 0);

        // 8-bit pattern A5 after three arbitrary bits.
        do_reset();
        load(8'hA5);
        for (int k = 0; k < 3; k++) begin
            send(1'($urandom_range(0, 1)));
            check($sformatf("p5_d_out_rnd%0d", k), 32'(if_d.out), 0);
        end
        pv = 8'hA5;
        for (int k = 7; k >= 0; k--) begin
            send(pv[k]);
            check($sformatf("p5_d_out_pb%0d", 8 - k), 32'(if_d.out), (k == 0) ? 1 : 0);
        end
        check("p5_d_cnt", 32'(if_d.match_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector, the generalised successor of the fixed 4-state sequence detector. It watches a 1-bit serial stream and pulses `out` whenever the last `PAT_W` accepted bits equal a runtime-programmable pattern. Overlapping or non-overlapping detection is selectable by parameter, and a saturating match counter is kept alongside. It sits directly on the serial input path, in the same slot as the fixed detectors, and is driven by the same testbench harness.

## Interface
- `PAT_W`, 4, pattern length in bits, 2..32
- `OVERLAP`, 1, 1 = overlapping matches allowed; 0 = history cleared after each match
- `CNT_W`, 8, width of match counter
- `RST_PAT`, 4'b1011 (zero-extended to `PAT_W`), pattern active after reset

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `i` in 1: serial data bit
- `in_valid` in 1: `i` is sampled only when high
- `pat_load` in 1: load `pat_in` as the new pattern
- `pat_in` in `PAT_W`: new pattern; MSB is the first bit of the sequence
- `cnt_clr` in 1: synchronous clear of `match_cnt`
- `out` out 1: registered one-cycle match pulse
- `match_cnt` out `CNT_W`: saturating count of matches
- `state_o` out 2: current FSM state, for debug/cover

## Operation
- Registers:
  - `pat`: active pattern.
  - `hist[PAT_W-1:0]`: shift register. The newest bit enters at the LSB, so `{hist[PAT_W-2:0], i}` is the candidate window.
  - `fill`: count of valid bits in `hist`, 0..`PAT_W`, width `$clog2(PAT_W+1)`.
- FSM states, held in `state_o`:
  - FILL = 2'b00: `fill < PAT_W-1`.
  - ARMED = 2'b01: `fill >= PAT_W-1`; the next accepted bit can complete a match.
  - MATCH = 2'b10: the previous accepted bit completed a match. Behaves as ARMED for the next bit.
  - 2'b11 is unused. The FSM recovers to FILL and clears `fill`.
- Accept, when `in_valid` is high and `pat_load` is low:
  - shift `i` into `hist`;
  - `fill` increments and saturates at `PAT_W`.
- Match condition: state is ARMED or MATCH and `{hist[PAT_W-2:0], i} == pat` on an accepted bit. On a match:
  - `out` goes to 1 and the next state is MATCH;
  - `match_cnt` increments, saturating at all-ones;
  - with `OVERLAP=1`, `fill` stays at `PAT_W`;
  - with `OVERLAP=0`, `fill` goes to 0, `hist` clears and the next state is FILL.
- Accepted bit with no match: `out` is 0. Next state is ARMED if the new `fill >= PAT_W-1`, else FILL.
- No accepted bit: `out` is 0 and `hist`/`fill` hold. MATCH falls back to ARMED, or to FILL when `OVERLAP=0`.
- `pat_load` high:
  - `pat <= pat_in`, `hist`/`fill` clear, state goes to FILL, `out` is 0;
  - the bit on `i` that cycle is discarded, even if `in_valid` is high;
  - `match_cnt` is untouched.
- `cnt_clr` high: `match_cnt <= 0`. If a match occurs in the same cycle, the clear wins and the count stays 0. `out` still pulses.
- Reset values: `pat=RST_PAT`, `hist=0`, `fill=0`, state FILL, `out=0`, `match_cnt=0`.

## Timing
- `out` is registered. It rises on the same rising edge that samples the completing bit and stays high for exactly one cycle, unless the next accepted bit also completes a match.
- Latency from the last pattern bit to `out`: 0 cycles after its sampling edge, i.e. visible one cycle after the bit is presented.
- Back-to-back matches with `OVERLAP=1` and a periodic pattern (e.g. 1111) hold `out` high on consecutive cycles.
- `match_cnt` updates on the same edge as `out`.
- A new pattern takes effect for bits accepted from the cycle after `pat_load`. The first possible match comes `PAT_W` accepted bits later.
- Reset is asynchronous: all registers clear immediately. A match in progress is lost, and no pulse is generated on deassertion.
- `in_valid` gaps do not break a sequence. Bits separated by idle cycles still match.

## Structure
- Package `seq_det_pkg`:
  - `typedef enum logic [1:0] {FILL, ARMED, MATCH} seq_state_t`
  - default constants for `PAT_W`, `CNT_W` and `RST_PAT`
- Sub-module `seq_det_window`: `hist` shift register plus `fill` counter, with inputs shift/clear and outputs window/`fill`. The top level holds the FSM, the compare, `out` and the counter.
- Estimated 150–250 lines of RTL.

## Test plan
- Reset default (`PAT_W=4`, `RST_PAT=1011`, `OVERLAP=1`), stream 1,0,1,1,0,1,1 with `in_valid` high: `out` pulses after bit 4 and after bit 7; `match_cnt=2`.
- `OVERLAP=0`, same stream: one pulse after bit 4; `match_cnt=1`; state returns to FILL.
- `pat_load` with `pat_in=1111` while `in_valid=1` and `i=1`: that bit is discarded. Then 1,1,1,1,1 gives pulses after bits 4 and 5, with `out` high for 2 consecutive cycles.
- Stream 1,0,(idle 3 cycles),1,1: a match is still detected. Separately, assert `rst` mid-sequence after 1,0,1: `out`, `fill` and `match_cnt` are 0 at once, and a following lone 1 produces no pulse.
- `CNT_W=2`, 5 matches: `match_cnt` saturates at 3. `cnt_clr` coincident with a 6th match: `match_cnt=0` and `out=1`.
- `PAT_W=8`, `pat_in=8'hA5`: the stream of bits of 0xA5 MSB-first, preceded by 3 random bits, gives exactly one pulse on the 8th pattern bit.
